plane_setup_seq: RTL and testbench
==================================

Name: plane_setup_seq

Overview:
Sequential per-triangle plane-equation setup for the PVR rasteriser. It sits directly upstream of the per-pixel interpolator. It accepts three fixed-point vertices (X, Y, attribute Z) and computes the plane coefficients FDDX, FDDY and small_c over many cycles with one shared serial divider, replacing the wide combinational divide. Results are handed downstream via valid/ready and held until consumed.

Parameters:
DIV_ITERS, 64, radix-2 divider iterations (dividend magnitude width).
PROD_W, 48, width of Aa/Ba/BIG_C after shift-truncation.

Ports:
clock  input  1  single system clock.
reset  input  1  synchronous, active-high reset.
FRAC_BITS  input  8  fixed-point fraction bits; sampled on input handshake.
in_valid  input  1  vertex set valid.
in_ready  output  1  high only in S_IDLE.
FX1, FX2, FX3  input  32 each  signed vertex X.
FY1, FY2, FY3  input  32 each  signed vertex Y.
FZ1, FZ2, FZ3  input  32 each  signed vertex attribute.
out_valid  output  1  coefficients valid.
out_ready  input  1  downstream accepts.
FDDX  output  32  signed d(attr)/dx, fixed-point.
FDDY  output  32  signed d(attr)/dy, fixed-point.
small_c  output  32  signed plane constant.
degenerate  output  1  BIG_C was zero for this triangle.

Behaviour:
- Reset: state S_IDLE; out_valid=0, FDDX=FDDY=small_c=0, degenerate=0. in_ready is then 1. Reset mid-operation drops in-flight work; nothing is emitted.
- Accept on in_valid && in_ready; latch all nine inputs plus FRAC_BITS.
- FSM: S_IDLE -> S_DIFF -> S_MUL -> S_DIV (DIV_ITERS cycles) -> S_CONST -> S_DONE -> S_IDLE.
- S_DIFF: register the 32-bit differences FZ3-FZ1, FZ2-FZ1, FY2-FY1, FY3-FY1, FX2-FX1, FX3-FX1 (wrap on overflow).
- S_MUL: compute 64-bit signed products, arithmetic-shift right by FRAC_BITS, truncate to PROD_W:
  - Aa = (dZ31*dY21)>>>F - (dZ21*dY31)>>>F
  - Ba = (dX31*dZ21)>>>F - (dX21*dZ31)>>>F
  - BIG_C = (dX31*dY21)>>>F - (dX21*dY31)>>>F (negated C)
  - Load both dividends: magnitude of (Aa<<<F) and (Ba<<<F), each zero-extended to DIV_ITERS bits.
- S_DIV: two parallel restoring unsigned dividers share the divisor |BIG_C|, one quotient bit per cycle, MSB first.
  - Quotient sign = dividend sign XOR divisor sign. Rounding truncates toward zero.
  - FDDX/FDDY take the low 32 bits.
- S_CONST: small_c = FZ1 - ((FDDX*FX1)>>>F) - ((FDDY*FY1)>>>F), low 32 bits.
- S_DONE: out_valid=1. All outputs are stable while out_valid && !out_ready. On out_ready go to S_IDLE, and out_valid falls the next cycle. A new input is accepted at the earliest one cycle after the output handshake.
- Latency: out_valid rises DIV_ITERS+3 cycles after the acceptance edge (67 by default).
- BIG_C==0: FDDX=FDDY=0, small_c=FZ1, degenerate=1. This is forced regardless of divider contents.
- degenerate is registered with the other outputs and cleared on the next acceptance.

Optional Feature:
PLANE_SETUP_EARLY_EXIT_EN:
- Defined: when BIG_C==0 at the end of S_MUL, the FSM goes S_MUL -> S_CONST, skipping S_DIV. Latency is 3 cycles.
- Undefined: S_DIV always runs the full DIV_ITERS. The degenerate outputs are still forced, and latency is always DIV_ITERS+3.

Decomposition:
- Package pvr_setup_pkg holds:
  - state enum (S_IDLE, S_DIFF, S_MUL, S_DIV, S_CONST, S_DONE);
  - width constants COORD_W=32, PROD_W=48;
  - default DIV_ITERS.
- One sub-module, setup_serdiv: a restoring signed serial divider with start/done, instantiated twice (dividends Aa and Ba, shared divisor).

Test Plan:
- Plane z=x, F=8. Vertices (0,0,0), (2560,0,2560), (0,2560,0). Expect FDDX=256, FDDY=0, small_c=0, degenerate=0, out_valid 67 cycles after accept.
- Plane z=1280+y. Vertices (0,0,1280), (2560,0,1280), (0,2560,3840). Expect FDDX=0, FDDY=256, small_c=1280.
- Negative slope. Vertices (0,0,0), (2560,0,-2560), (0,2560,0). Expect FDDX=-256 (0xFFFFFF00), FDDY=0, small_c=0.
- Collinear. Vertices (0,0,77), (2560,0,5), (5120,0,9). Expect FDDX=0, FDDY=0, small_c=77, degenerate=1. Latency is 3 cycles with PLANE_SETUP_EARLY_EXIT_EN, 67 without.
- Backpressure. Hold out_ready=0 for 10 cycles after out_valid. Outputs and out_valid stay constant, in_ready=0. Release: one handshake, then in_ready=1 next cycle.
- Reset asserted in cycle 30 of S_DIV. out_valid never rises, in_ready=1 after reset. The next triangle (first scenario) yields FDDX=256 with full latency.

Source files
------------

// File: rtl/pvr_setup_pkg.sv
// Shared types and constants for the PVR triangle plane-equation setup block.
package pvr_setup_pkg;

    localparam int COORD_W           = 32;
    localparam int PROD_W            = 48;
    localparam int DIV_ITERS_DEFAULT = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIFF,
        S_MUL,
        S_DIV,
        S_CONST,
        S_DONE
    } state_t;

    // Full-precision signed 32x32 product; operands are sign-extended first.
    function automatic logic signed [63:0] smul(
        input logic signed [COORD_W-1:0] a,
        input logic signed [COORD_W-1:0] b
    );
        return 64'(a) * 64'(b);
    endfunction

endpackage

// File: rtl/setup_serdiv.sv
// Restoring signed serial divider: one quotient bit per cycle, MSB first,
// truncating toward zero. i_start loads operands; o_last flags the cycle that
// performs the final iteration, so o_quotient is valid right after that edge
// and holds until the next start.
module setup_serdiv
    import pvr_setup_pkg::*;
#(
    parameter int DIV_ITERS = DIV_ITERS_DEFAULT,
    parameter int DVS_W     = PROD_W,
    parameter int Q_W       = COORD_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [DIV_ITERS-1:0] i_dividend,
    input  logic [DVS_W-1:0]     i_divisor,
    output logic                 o_last,
    output logic [Q_W-1:0]       o_quotient
);

    localparam int CNT_W = $clog2(DIV_ITERS + 1);

    logic                 r_busy;
    logic [CNT_W-1:0]     r_count;
    logic [DVS_W-1:0]     r_rem;
    logic [DVS_W-1:0]     r_dvs_mag;
    logic [DIV_ITERS-1:0] r_quo;
    logic                 r_neg;

    logic [DIV_ITERS-1:0] w_dvd_mag;
    logic [DVS_W-1:0]     w_dvs_mag;
    logic [DVS_W:0]       w_shift;
    logic [DVS_W-1:0]     w_diff;
    logic                 w_fits;
    logic [Q_W-1:0]       w_q_low;

    // Operate on magnitudes; the sign is reapplied to the finished quotient.
    assign w_dvd_mag = i_dividend[DIV_ITERS-1] ? (DIV_ITERS'(0) - i_dividend) : i_dividend;
    assign w_dvs_mag = i_divisor[DVS_W-1] ? (DVS_W'(0) - i_divisor) : i_divisor;

    // Partial remainder stays below the divisor, so one extra bit covers the shift.
    assign w_shift = {r_rem, r_quo[DIV_ITERS-1]};
    assign w_fits  = (w_shift >= {1'b0, r_dvs_mag});
    assign w_diff  = DVS_W'(w_shift - {1'b0, r_dvs_mag});

    assign w_q_low    = r_quo[Q_W-1:0];
    assign o_quotient = r_neg ? (Q_W'(0) - w_q_low) : w_q_low;
    assign o_last     = r_busy && (r_count == CNT_W'(DIV_ITERS - 1));

    // Iteration control: busy flag and iteration counter.
    // NOTE: every clocked register is written with <= so all flops update
    // together at the edge regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_count <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_count <= '0;
        end else if (r_busy) begin
            r_count <= r_count + CNT_W'(1);
            if (o_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Datapath: load operands on start, then shift/subtract once per cycle.
    // NOTE: datapath registers carry no reset; they are always loaded by
    // i_start before anything reads them, and skipping the reset keeps the
    // wide shift registers cheap.
    always_ff @(posedge clock) begin
        if (i_start) begin
            r_rem     <= '0;
            r_quo     <= w_dvd_mag;
            r_dvs_mag <= w_dvs_mag;
            r_neg     <= i_dividend[DIV_ITERS-1] ^ i_divisor[DVS_W-1];
        end else if (r_busy) begin
            r_rem <= w_fits ? w_diff : w_shift[DVS_W-1:0];
            r_quo <= {r_quo[DIV_ITERS-2:0], w_fits};
        end
    end

endmodule

// File: rtl/plane_setup_seq.sv
// Sequential per-triangle plane-equation setup (FDDX, FDDY, small_c) feeding
// the per-pixel interpolator. One pass: diff -> multiply -> serial divide ->
// constant term, results held on a valid/ready output until consumed.
// Build option: define PLANE_SETUP_EARLY_EXIT_EN to skip the divide phase
// for degenerate (BIG_C == 0) triangles.
module plane_setup_seq
    import pvr_setup_pkg::*;
#(
    parameter int DIV_ITERS = DIV_ITERS_DEFAULT,
    parameter int PROD_W    = pvr_setup_pkg::PROD_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  FRAC_BITS,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] FX1,
    input  logic [31:0] FX2,
    input  logic [31:0] FX3,
    input  logic [31:0] FY1,
    input  logic [31:0] FY2,
    input  logic [31:0] FY3,
    input  logic [31:0] FZ1,
    input  logic [31:0] FZ2,
    input  logic [31:0] FZ3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] FDDX,
    output logic [31:0] FDDY,
    output logic [31:0] small_c,
    output logic        degenerate
);

    state_t                    r_state;
    logic [7:0]                r_frac;
    logic signed [COORD_W-1:0] r_x1, r_y1, r_z1, r_x2, r_y2, r_z2, r_x3, r_y3, r_z3;
    logic signed [COORD_W-1:0] r_dz31, r_dz21, r_dy21, r_dy31, r_dx21, r_dx31;
    logic signed [PROD_W-1:0]  r_big_c;
    logic                      r_out_valid;
    logic                      r_degenerate;
    logic [31:0]               r_fddx, r_fddy, r_small_c;

    logic signed [63:0]        w_zy_a, w_zy_b, w_xz_a, w_xz_b, w_xy_a, w_xy_b;
    logic signed [PROD_W-1:0]  w_aa, w_ba, w_big_c;
    logic [DIV_ITERS-1:0]      w_dvd_a, w_dvd_b;
    logic                      w_div_start;
    logic                      w_last_a, w_last_b;
    logic [COORD_W-1:0]        w_quo_a, w_quo_b;
    logic                      w_big_c_zero;
    logic signed [COORD_W-1:0] w_fddx, w_fddy, w_small_c;

    // Cross products of the edge vectors, each scaled back by the fraction bits
    // before the difference so both terms share the same fixed-point format.
    assign w_zy_a = smul(r_dz31, r_dy21) >>> r_frac;
    assign w_zy_b = smul(r_dz21, r_dy31) >>> r_frac;
    assign w_xz_a = smul(r_dx31, r_dz21) >>> r_frac;
    assign w_xz_b = smul(r_dx21, r_dz31) >>> r_frac;
    assign w_xy_a = smul(r_dx31, r_dy21) >>> r_frac;
    assign w_xy_b = smul(r_dx21, r_dy31) >>> r_frac;

    assign w_aa    = PROD_W'(w_zy_a - w_zy_b);
    assign w_ba    = PROD_W'(w_xz_a - w_xz_b);
    assign w_big_c = PROD_W'(w_xy_a - w_xy_b);

    // Pre-scale dividends so the quotient comes out in the same fixed-point format.
    assign w_dvd_a = DIV_ITERS'(w_aa) << r_frac;
    assign w_dvd_b = DIV_ITERS'(w_ba) << r_frac;

    assign w_div_start = (r_state == S_MUL);

    setup_serdiv #(
        .DIV_ITERS (DIV_ITERS),
        .DVS_W     (PROD_W),
        .Q_W       (COORD_W)
    ) u_div_a (
        .clock      (clock),
        .reset      (reset),
        .i_start    (w_div_start),
        .i_dividend (w_dvd_a),
        .i_divisor  (w_big_c),
        .o_last     (w_last_a),
        .o_quotient (w_quo_a)
    );

    setup_serdiv #(
        .DIV_ITERS (DIV_ITERS),
        .DVS_W     (PROD_W),
        .Q_W       (COORD_W)
    ) u_div_b (
        .clock      (clock),
        .reset      (reset),
        .i_start    (w_div_start),
        .i_dividend (w_dvd_b),
        .i_divisor  (w_big_c),
        .o_last     (w_last_b),
        .o_quotient (w_quo_b)
    );

    // A zero-area triangle has no meaningful gradient: force a flat plane at Z1,
    // ignoring whatever the divider produced for a zero divisor.
    assign w_big_c_zero = (r_big_c == '0);
    assign w_fddx       = w_big_c_zero ? '0 : w_quo_a;
    assign w_fddy       = w_big_c_zero ? '0 : w_quo_b;
    assign w_small_c    = w_big_c_zero ? r_z1
                        : r_z1 - 32'(smul(w_fddx, r_x1) >>> r_frac)
                               - 32'(smul(w_fddy, r_y1) >>> r_frac);

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = r_out_valid;
    assign FDDX       = r_fddx;
    assign FDDY       = r_fddy;
    assign small_c    = r_small_c;
    assign degenerate = r_degenerate;

    // Control FSM plus the registered result outputs it owns.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_out_valid  <= 1'b0;
            r_fddx       <= '0;
            r_fddy       <= '0;
            r_small_c    <= '0;
            r_degenerate <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_degenerate <= 1'b0;
                        r_state      <= S_DIFF;
                    end
                end
                S_DIFF: begin
                    r_state <= S_MUL;
                end
                S_MUL: begin
`ifdef PLANE_SETUP_EARLY_EXIT_EN
                    r_state <= (w_big_c == '0) ? S_CONST : S_DIV;
`else
                    r_state <= S_DIV;
`endif
                end
                S_DIV: begin
                    if (w_last_a && w_last_b) begin
                        r_state <= S_CONST;
                    end
                end
                S_CONST: begin
                    r_fddx       <= w_fddx;
                    r_fddy       <= w_fddy;
                    r_small_c    <= w_small_c;
                    r_degenerate <= w_big_c_zero;
                    r_out_valid  <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand capture on acceptance, edge differences, and the latched divisor.
    always_ff @(posedge clock) begin
        if (r_state == S_IDLE && in_valid) begin
            r_frac <= FRAC_BITS;
            r_x1   <= FX1;
            r_y1   <= FY1;
            r_z1   <= FZ1;
            r_x2   <= FX2;
            r_y2   <= FY2;
            r_z2   <= FZ2;
            r_x3   <= FX3;
            r_y3   <= FY3;
            r_z3   <= FZ3;
        end
        if (r_state == S_DIFF) begin
            r_dz31 <= r_z3 - r_z1;
            r_dz21 <= r_z2 - r_z1;
            r_dy21 <= r_y2 - r_y1;
            r_dy31 <= r_y3 - r_y1;
            r_dx21 <= r_x2 - r_x1;
            r_dx31 <= r_x3 - r_x1;
        end
        if (r_state == S_MUL) begin
            r_big_c <= w_big_c;
        end
    end

endmodule

// File: tb/tb_plane_setup_seq.sv
// Directed testbench for plane_setup_seq with hand-computed plane coefficients.
module tb_plane_setup_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  FRAC_BITS;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] FX1, FX2, FX3, FY1, FY2, FY3, FZ1, FZ2, FZ3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] FDDX, FDDY, small_c;
    logic        degenerate;

    int errors = 0;
    int checks = 0;

    localparam int FULL_LAT   = 67;
`ifdef PLANE_SETUP_EARLY_EXIT_EN
    localparam int DEGEN_LAT  = 3;
`else
    localparam int DEGEN_LAT  = 67;
`endif
    localparam int WAIT_LIMIT = 300;

    typedef struct {
        int f;
        int x1, y1, z1;
        int x2, y2, z2;
        int x3, y3, z3;
        int ex, ey, ec;
    } vec_t;

    localparam vec_t V_PLANE_X = '{8, 0, 0, 0, 2560, 0, 2560, 0, 2560, 0, 256, 0, 0};
    localparam vec_t V_PLANE_Y = '{8, 0, 0, 1280, 2560, 0, 1280, 0, 2560, 3840, 0, 256, 1280};
    localparam vec_t V_NEG_X   = '{8, 0, 0, 0, 2560, 0, -2560, 0, 2560, 0, -256, 0, 0};
    localparam vec_t V_COLLIN  = '{8, 0, 0, 77, 2560, 0, 5, 5120, 0, 9, 0, 0, 77};

    always #5 clock = ~clock;

    plane_setup_seq dut (
        .clock      (clock),
        .reset      (reset),
        .FRAC_BITS  (FRAC_BITS),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .FX1        (FX1),
        .FX2        (FX2),
        .FX3        (FX3),
        .FY1        (FY1),
        .FY2        (FY2),
        .FY3        (FY3),
        .FZ1        (FZ1),
        .FZ2        (FZ2),
        .FZ3        (FZ3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .FDDX       (FDDX),
        .FDDY       (FDDY),
        .small_c    (small_c),
        .degenerate (degenerate)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a vertex set and return just after the acceptance edge.
    task automatic accept(input vec_t v);
        int n;
        n = 0;
        FRAC_BITS = 8'(v.f);
        FX1 = v.x1; FY1 = v.y1; FZ1 = v.z1;
        FX2 = v.x2; FY2 = v.y2; FZ2 = v.z2;
        FX3 = v.x3; FY3 = v.y3; FZ3 = v.z3;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < WAIT_LIMIT) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        step();
        in_valid = 1'b0;
    endtask

    // Count cycles from the acceptance edge until out_valid is seen high.
    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < WAIT_LIMIT) begin
            step();
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        FRAC_BITS = '0;
        FX1 = '0; FX2 = '0; FX3 = '0;
        FY1 = '0; FY2 = '0; FY3 = '0;
        FZ1 = '0; FZ2 = '0; FZ3 = '0;
        step(); step(); step();
        reset = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (FDDX !== 32'd0) begin errors++; $display("FAIL reset_fddx: got %h expected 0", FDDX); end
        checks++; if (FDDY !== 32'd0) begin errors++; $display("FAIL reset_fddy: got %h expected 0", FDDY); end
        checks++; if (small_c !== 32'd0) begin errors++; $display("FAIL reset_small_c: got %h expected 0", small_c); end
        checks++; if (degenerate !== 1'b0) begin errors++; $display("FAIL reset_degenerate: got %b expected 0", degenerate); end
    endtask

    task automatic test_directed_planes();
        vec_t vecs[9];
        int lat;
        vecs[0] = V_PLANE_X;
        vecs[1] = V_PLANE_Y;
        vecs[2] = V_NEG_X;
        vecs[3] = '{8, 256, 0, 0, 2816, 0, 2560, 256, 2560, 0, 256, 0, -256};
        vecs[4] = '{8, 0, 512, 1280, 2560, 512, 1280, 0, 3072, 3840, 0, 256, 768};
        vecs[5] = '{8, 0, 0, 0, 768, 0, -256, 0, 768, 0, -85, 0, 0};
        vecs[6] = '{4, 0, 0, 0, 2560, 0, 2560, 0, 2560, 0, 16, 0, 0};
        vecs[7] = '{8, 256, 0, 0, 2816, 0, -2560, 256, 2560, 0, -256, 0, 256};
        vecs[8] = '{8, 0, 0, 0, 2560, 0, 2560, 0, 2560, 2560, 256, 256, 0};
        for (int i = 0; i < 9; i++) begin
            accept(vecs[i]);
            wait_out(lat);
            checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, FULL_LAT); end
            checks++; if (FDDX !== 32'(vecs[i].ex)) begin errors++; $display("FAIL vec%0d_fddx: got %0d expected %0d", i, $signed(FDDX), vecs[i].ex); end
            checks++; if (FDDY !== 32'(vecs[i].ey)) begin errors++; $display("FAIL vec%0d_fddy: got %0d expected %0d", i, $signed(FDDY), vecs[i].ey); end
            checks++; if (small_c !== 32'(vecs[i].ec)) begin errors++; $display("FAIL vec%0d_small_c: got %0d expected %0d", i, $signed(small_c), vecs[i].ec); end
            checks++; if (degenerate !== 1'b0) begin errors++; $display("FAIL vec%0d_degenerate: got %b expected 0", i, degenerate); end
            release_out();
        end
    endtask

    task automatic test_degenerate();
        int lat;
        accept(V_COLLIN);
        wait_out(lat);
        checks++; if (lat != DEGEN_LAT) begin errors++; $display("FAIL degen_latency: got %0d expected %0d", lat, DEGEN_LAT); end
        checks++; if (FDDX !== 32'd0) begin errors++; $display("FAIL degen_fddx: got %h expected 0", FDDX); end
        checks++; if (FDDY !== 32'd0) begin errors++; $display("FAIL degen_fddy: got %h expected 0", FDDY); end
        checks++; if (small_c !== 32'd77) begin errors++; $display("FAIL degen_small_c: got %0d expected 77", $signed(small_c)); end
        checks++; if (degenerate !== 1'b1) begin errors++; $display("FAIL degen_flag: got %b expected 1", degenerate); end
        release_out();
        // The flag must clear on the very next acceptance.
        accept(V_PLANE_X);
        checks++; if (degenerate !== 1'b0) begin errors++; $display("FAIL degen_clear: got %b expected 0", degenerate); end
        wait_out(lat);
        checks++; if (FDDX !== 32'd256) begin errors++; $display("FAIL degen_next_fddx: got %0d expected 256", $signed(FDDX)); end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        accept(V_PLANE_Y);
        wait_out(lat);
        checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, FULL_LAT); end
        for (int c = 0; c < 10; c++) begin
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c%0d: got %b expected 1", c, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready c%0d: got %b expected 0", c, in_ready); end
            checks++; if (FDDX !== 32'd0) begin errors++; $display("FAIL bp_hold_fddx c%0d: got %h expected 0", c, FDDX); end
            checks++; if (FDDY !== 32'd256) begin errors++; $display("FAIL bp_hold_fddy c%0d: got %0d expected 256", c, $signed(FDDY)); end
            checks++; if (small_c !== 32'd1280) begin errors++; $display("FAIL bp_hold_small_c c%0d: got %0d expected 1280", c, $signed(small_c)); end
        end
        release_out();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        int lat;
        accept(V_PLANE_X);
        wait_out(lat);
        checks++; if (FDDX !== 32'd256) begin errors++; $display("FAIL b2b_first_fddx: got %0d expected 256", $signed(FDDX)); end
        release_out();
        accept(V_NEG_X);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap_valid: got %b expected 0", out_valid); end
        wait_out(lat);
        checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, FULL_LAT); end
        checks++; if (FDDX !== 32'hFFFF_FF00) begin errors++; $display("FAIL b2b_second_fddx: got %h expected ffffff00", FDDX); end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen_valid;
        accept(V_PLANE_X);
        // Two cycles to reach S_DIV, then 29 more to sit in its 30th cycle.
        for (int c = 0; c < 31; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        checks++; if (FDDX !== 32'd0) begin errors++; $display("FAIL midrst_fddx: got %h expected 0", FDDX); end
        seen_valid = 1'b0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output: out_valid rose=%b expected 0", seen_valid); end
        accept(V_PLANE_X);
        wait_out(lat);
        checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL midrst_latency: got %0d expected %0d", lat, FULL_LAT); end
        checks++; if (FDDX !== 32'd256) begin errors++; $display("FAIL midrst_fddx_after: got %0d expected 256", $signed(FDDX)); end
        release_out();
    endtask

    initial begin
        test_reset();
        test_directed_planes();
        test_degenerate();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
